// File: rtl/seg7_capture.sv
// seg7_capture: watches the anode/cathode lines of a multiplexed 7-segment
// display driver and reconstructs the value shown on every digit.
// Optional feature: define SEG7_CAPTURE_DP_EN to also capture decimal points;
// without it cathode[7] is ignored and digit_dp stays 0.
module seg7_capture #(
  parameter int NUM_SEGMENTS  = 8,
  parameter int CLK_PER       = 10,
  parameter int REFR_RATE     = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      CPU_RESET,
  input  logic [NUM_SEGMENTS-1:0]   anode,
  input  logic [7:0]                cathode,
  output logic [4*NUM_SEGMENTS-1:0] digit_val,
  output logic [NUM_SEGMENTS-1:0]   digit_dp,
  output logic [NUM_SEGMENTS-1:0]   digit_valid,
  output logic                      frame_done,
  output logic                      glyph_err,
  output logic                      stale
);

  localparam int IW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
`ifdef SEG7_CAPTURE_DP_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_SAT  = 8'(SETTLE_CYCLES);
  // Watchdog window: four nominal refresh periods, in clocks.
  localparam logic [63:0] WD_LIMIT_L  =
    64'd4_000_000_000 / (64'(CLK_PER) * 64'(REFR_RATE));
  localparam logic [31:0] WD_LIMIT    = 32'(WD_LIMIT_L);

  logic [NUM_SEGMENTS-1:0] anode_s1, anode_s2, anode_p;
  logic [CW-1:0]           cath_s1, cath_s2, cath_p;
  logic [7:0]              settle_cnt;
  logic [NUM_SEGMENTS-1:0] seen, seen_next;
  logic [31:0]             wd_cnt;
  logic                    stable, legal, capture, blank;
  logic [IW-1:0]           idx;
  logic [4:0]              dec;

  // Returns {hit, nibble} for an active-low CA..CG pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // Two-flop synchronizers plus a one-cycle-old copy for the stability compare.
  always_ff @(posedge clk) begin
    if (CPU_RESET) begin
      anode_s1 <= '0;
      anode_s2 <= '0;
      anode_p  <= '0;
      cath_s1  <= '0;
      cath_s2  <= '0;
      cath_p   <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's old
      // value; blocking assignments would collapse the chain into one flop.
      anode_s1 <= anode;
      anode_s2 <= anode_s1;
      anode_p  <= anode_s2;
      cath_s1  <= cathode[CW-1:0];
      cath_s2  <= cath_s1;
      cath_p   <= cath_s2;
    end
  end

  // Digit selection, stability and capture decision.
  always_comb begin
    // NOTE: every variable gets a default before the conditional loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    idx       = '0;
    stable    = (anode_s2 == anode_p) && (cath_s2 == cath_p);
    legal     = ($countones(~anode_s2) == 1);
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (!anode_s2[i]) idx = IW'(i);
    end
    capture   = stable && legal && (settle_cnt == SETTLE_LAST);
    dec       = decode(cath_s2[6:0]);
    blank     = (cath_s2[6:0] == 7'h7F);
    seen_next = seen | (NUM_SEGMENTS'(1) << idx);
  end

  // Settle counter: saturates past the capture point so a dwell captures once.
  always_ff @(posedge clk) begin
    if (CPU_RESET)                settle_cnt <= '0;
    else if (!stable || !legal)   settle_cnt <= '0;
    else if (settle_cnt != SETTLE_SAT) settle_cnt <= settle_cnt + 8'd1;
  end

  // Per-digit results, frame tracking and glyph error pulse.
  always_ff @(posedge clk) begin
    if (CPU_RESET) begin
      // NOTE: digit_val is a small register bank driving outputs, so it is
      // reset like any flop; a real RAM array would be left unreset.
      digit_val   <= '0;
      digit_valid <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      glyph_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      glyph_err  <= 1'b0;
      if (capture) begin
        if (dec[4]) begin
          digit_val[4*idx +: 4] <= dec[3:0];
          digit_valid[idx]      <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
          glyph_err        <= !blank;
        end
        if (&seen_next) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  // Decimal point follows every capture of its digit, blank or not.
  always_ff @(posedge clk) begin
    if (CPU_RESET)    digit_dp <= '0;
    else if (capture) digit_dp[idx] <= ~cath_s2[7];
  end
`else
  assign digit_dp = '0;
  logic unused_dp;
  assign unused_dp = cathode[7];
`endif

  // Watchdog: clocks since the last capture, saturating at the window.
  always_ff @(posedge clk) begin
    if (CPU_RESET) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else if (capture) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else if (wd_cnt < WD_LIMIT) begin
      wd_cnt <= wd_cnt + 32'd1;
      stale  <= (wd_cnt + 32'd1 == WD_LIMIT);
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed stimulus for seg7_capture with a queue-based
// scoreboard; the watchdog window is shortened through REFR_RATE.
module tb_seg7_capture;

  localparam int N         = 8;
  localparam int S         = 4;
  localparam int CLK_PER   = 10;
  localparam int REFR_RATE = 1_000_000;
  localparam int WD_LIMIT  = 400;   // 4e9 / (10 * 1e6)
`ifdef SEG7_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           CPU_RESET;
  logic [N-1:0]   anode;
  logic [7:0]     cathode;
  logic [4*N-1:0] digit_val;
  logic [N-1:0]   digit_dp, digit_valid;
  logic           frame_done, glyph_err, stale;

  seg7_capture #(
    .NUM_SEGMENTS (N),
    .CLK_PER      (CLK_PER),
    .REFR_RATE    (REFR_RATE),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .CPU_RESET  (CPU_RESET),
    .anode      (anode),
    .cathode    (cathode),
    .digit_val  (digit_val),
    .digit_dp   (digit_dp),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .glyph_err  (glyph_err),
    .stale      (stale)
  );

  always #(CLK_PER/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4*N-1:0] val;
    logic [N-1:0]   dp;
    logic [N-1:0]   valid;
    logic           glyph;
    logic           frame;
  } exp_t;

  exp_t           sb_q[$];
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dp, m_valid, m_seen;
  int checks = 0, errors = 0, frame_cnt = 0, glyph_cnt = 0, last_upd = 0;
  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_val = '0; m_dp = '0; m_valid = '0; m_seen = '0;
  endtask

  // Applies the expected effect of one dwell to the model.
  task automatic model_capture(input logic [N-1:0] a, input logic [7:0] c, output exp_t e);
    int i = 0;
    int nib = -1;
    logic [7:0] pat;
    e.glyph = 1'b0;
    e.frame = 1'b0;
    if ($countones(~a) == 1) begin
      for (int k = 0; k < N; k++) if (a[k] == 1'b0) i = k;
      pat = c | 8'h80;
      for (int t = 0; t < 16; t++) if (pat == glyph_tab[t]) nib = t;
      if (nib >= 0) begin
        m_val[4*i +: 4] = nib[3:0];
        m_valid[i]      = 1'b1;
      end else begin
        m_valid[i] = 1'b0;
        e.glyph    = (pat != 8'hFF);
      end
      m_dp[i]   = DP_EN & ~c[7];
      m_seen[i] = 1'b1;
      if (&m_seen) begin
        e.frame = 1'b1;
        m_seen  = '0;
      end
    end
    e.val = m_val; e.dp = m_dp; e.valid = m_valid;
  endtask

  // Holds one anode/cathode pair for len cycles and scores the result.
  task automatic dwell(input logic [N-1:0] a, input logic [7:0] c, input int len,
                       input logic stale_pre);
    exp_t pre, e, got;
    logic cap;
    int   start;
    pre.val = m_val; pre.dp = m_dp; pre.valid = m_valid;
    cap     = ($countones(~a) == 1);
    anode   = a;
    cathode = c;
    start   = cyc;
    model_capture(a, c, e);
    sb_q.push_back(e);
    for (int k = 1; k <= len; k++) begin
      tick(1);
      if (frame_done) frame_cnt++;
      if (glyph_err)  glyph_cnt++;
      if (k == S + 2) begin
        check("early_val",   digit_val,   pre.val);
        check("early_valid", digit_valid, pre.valid);
        check("early_stale", stale,       stale_pre);
      end else if (k == S + 3) begin
        got = sb_q.pop_front();
        check("val",   digit_val,   got.val);
        check("dp",    digit_dp,    got.dp);
        check("valid", digit_valid, got.valid);
        check("glyph", glyph_err,   got.glyph);
        check("frame", frame_done,  got.frame);
        check("stale", stale,       cap ? 1'b0 : stale_pre);
        if (cap) last_upd = start + S + 3;
      end else begin
        check("stray_pulse", {glyph_err, frame_done}, 2'b00);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"},   digit_val,   0);
    check({tag, "_dp"},    digit_dp,    0);
    check({tag, "_valid"}, digit_valid, 0);
    check({tag, "_frame"}, frame_done,  0);
    check({tag, "_glyph"}, glyph_err,   0);
    check({tag, "_stale"}, stale,       0);
  endtask

  logic [N-1:0] a_sel;
  int           fc0, gc0, guard;

  initial begin
    CPU_RESET = 1'b1;
    anode     = '1;
    cathode   = 8'hFF;
    model_reset();
    tick(3);
    check_all_zero("reset");
    CPU_RESET = 1'b0;

    // Single digit, latency S+3.
    dwell(8'hFE, 8'hF9, 10, 1'b0);
    check("d0_is_1", digit_val[3:0], 4'h1);

    // Two full frames of 0..7.
    for (int p = 0; p < 2; p++) begin
      fc0 = frame_cnt;
      for (int d = 0; d < N; d++) begin
        a_sel = ~(N'(1) << d);
        dwell(a_sel, glyph_tab[d], 20, 1'b0);
      end
      check("frames_per_pass", frame_cnt - fc0, 1);
    end
    check("frame_val",   digit_val,   32'h7654_3210);
    check("frame_valid", digit_valid, 8'hFF);

    // Blank then undecodable on digit 2.
    gc0 = glyph_cnt;
    dwell(8'hFB, 8'hFF, 14, 1'b0);
    check("blank_valid2", digit_valid[2], 1'b0);
    check("blank_noerr",  glyph_cnt - gc0, 0);
    dwell(8'hFB, 8'hAA, 14, 1'b0);
    check("err_val2",   digit_val[11:8], 4'h2);
    check("err_pulses", glyph_cnt - gc0, 1);

    // Two digits enabled at once, then a cathode that never settles.
    dwell(8'hFC, 8'hC0, 50, 1'b0);
    anode = 8'hFB;
    for (int j = 0; j < 20; j++) begin
      cathode = j[0] ? 8'hF9 : 8'hC0;
      tick(2);
    end
    check("toggle_val",   digit_val,   m_val);
    check("toggle_valid", digit_valid, m_valid);

    // Decimal point on digit 0.
    dwell(8'hFE, 8'h40, 14, 1'b0);
    check("dp_val0", digit_val[3:0], 4'h0);
    check("dp_bit0", digit_dp[0],    DP_EN);

    // Watchdog: idle display until stale.
    anode   = '1;
    cathode = 8'hFF;
    guard   = 0;
    while (cyc < last_upd + WD_LIMIT - 1 && guard < 2 * WD_LIMIT) begin
      tick(1);
      guard++;
    end
    check("wd_reached",   cyc,   last_upd + WD_LIMIT - 1);
    check("stale_before", stale, 1'b0);
    tick(1);
    check("stale_at_limit", stale, 1'b1);
    tick(30);
    check("stale_held", stale, 1'b1);
    dwell(8'hFD, 8'hA4, 12, 1'b1);
    check("stale_cleared", stale, 1'b0);

    // Reset in the middle of a dwell.
    anode   = 8'hFE;
    cathode = 8'h92;
    tick(3);
    CPU_RESET = 1'b1;
    tick(2);
    check_all_zero("rst_mid");
    CPU_RESET = 1'b0;
    anode     = '1;
    cathode   = 8'hFF;
    model_reset();
    tick(S + 8);
    check_all_zero("post_rst");
    dwell(8'hFE, 8'hC0, 12, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The module SHALL have parameter NUM_SEGMENTS, default 8: number of multiplexed digits observed.
REQ-002 The module SHALL have parameter CLK_PER, default 10: clock period in ns.
REQ-003 The module SHALL have parameter REFR_RATE, default 1000: nominal display refresh rate in Hz.
REQ-004 The module SHALL have parameter SETTLE_CYCLES, default 4: consecutive stable cycles required before a digit is captured; legal range 2..255.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock.
REQ-006 The module SHALL have port CPU_RESET, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port anode, input, NUM_SEGMENTS bits: active-low digit enables from a 7-segment driver.
REQ-008 The module SHALL have port cathode, input, 8 bits: active-low segments; bits 0..6 = CA..CG, bit 7 = DP.
REQ-009 The module SHALL have port digit_val, output, 4*NUM_SEGMENTS bits: decoded nibble per digit; digit i at bits 4i+3:4i.
REQ-010 The module SHALL have port digit_dp, output, NUM_SEGMENTS bits: captured decimal point per digit, active-high.
REQ-011 The module SHALL have port digit_valid, output, NUM_SEGMENTS bits: 1 = last capture of digit i decoded to a legal glyph.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse when every digit has been captured since the previous pulse.
REQ-013 The module SHALL have port glyph_err, output, 1 bit: one-cycle pulse on capture of an undecodable, non-blank pattern.
REQ-014 The module SHALL have port stale, output, 1 bit: level, high when no capture has occurred within the watchdog window.

Function
REQ-015 anode and cathode SHALL each pass through a 2-flop synchronizer before any other use.
REQ-016 A synchronized anode pattern with exactly one bit low SHALL select digit index i; any other pattern (none low, several low) SHALL be treated as idle and SHALL restart the settle count.
REQ-017 The settle counter SHALL increment while the synchronized {anode, cathode} equal their value from the previous cycle and SHALL reset to 0 on any change.
REQ-018 Capture SHALL occur exactly once per dwell, on the cycle the counter reaches SETTLE_CYCLES-1 with a legal anode; digit_val, digit_dp and digit_valid SHALL update on the following cycle (total latency from input change = SETTLE_CYCLES+3 cycles).
REQ-019 Decoding SHALL use cathode[6:0], active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (hex, cathode[7] taken as 1).
REQ-020 Pattern 7F (all segments off) SHALL be a blank: digit_val[i] retained, digit_valid[i] cleared, no glyph_err.
REQ-021 Any other undecodable pattern SHALL clear digit_valid[i], retain digit_val[i] and pulse glyph_err on the update cycle.
REQ-022 A per-digit seen mask SHALL set bit i on every capture (blank and error included); when all bits are set, frame_done SHALL pulse on the update cycle and the mask SHALL clear in the same cycle.
REQ-023 Recapture of an already-seen digit before the frame completes SHALL update its outputs and SHALL NOT affect frame_done.
REQ-024 The watchdog SHALL count clocks since the last capture; stale SHALL assert when the count reaches 4*1e9/(CLK_PER*REFR_RATE) (400000 at defaults), saturate there, and deassert on the update cycle of the next capture.

Reset
REQ-025 While CPU_RESET is high at a clk edge, all outputs SHALL clear: digit_val=0, digit_dp=0, digit_valid=0, frame_done=0, glyph_err=0, stale=0.
REQ-026 Reset SHALL clear the synchronizers, settle counter, seen mask and watchdog; a dwell in progress SHALL be discarded and no capture SHALL occur until SETTLE_CYCLES full stable cycles after reset release.

Configuration
REQ-027 With macro SEG7_CAPTURE_DP_EN defined, digit_dp[i] SHALL capture ~cathode[7] at each capture of digit i.
REQ-028 Without SEG7_CAPTURE_DP_EN, cathode[7] SHALL be ignored (not synchronized, not part of the stability compare) and digit_dp SHALL be constant 0.

Verification
REQ-029 Reset then hold anode=FE, cathode=F9 for 10 cycles -> digit_val[3:0]=1, digit_valid[0]=1 at cycle SETTLE_CYCLES+3 after input change, no glyph_err.
REQ-030 Cycle anode FE..7F, 20 cycles each, with cathodes for digits 0..7 = C0,F9,A4,B0,99,92,82,F8 -> digit_val=76543210 hex, digit_valid=FF, exactly one frame_done per 8 dwells.
REQ-031 Digit 2 with cathode=FF, then cathode=AA -> blank: digit_valid[2]=0, no glyph_err; AA: glyph_err single pulse, digit_val[11:8] unchanged.
REQ-032 anode=FC (two digits) for 50 cycles, and cathode toggling every 2 cycles with SETTLE_CYCLES=4 -> no capture, outputs unchanged.
REQ-033 Stop anode activity (anode=FF) -> stale asserts at 400000 cycles; next valid dwell -> stale clears on its update cycle; CPU_RESET mid-dwell -> all outputs 0, no capture from that dwell.
REQ-034 With SEG7_CAPTURE_DP_EN, cathode=40 on digit 0 -> digit_val[3:0]=0, digit_dp[0]=1; without it -> digit_dp=0.
